// File: rtl/ds_operand_bypass_pkg.sv
// Shared types and sizes for the decode-stage operand network.
// Branch kinds as the decoder encodes them, plus helpers for stage bus widths.
package ds_operand_bypass_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int RA_W_DEF    = 5;
   localparam int NUM_FWD_DEF = 3;
   localparam int INST_W      = 32;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_B    = 3'd1,
      BR_JIRL = 3'd2,
      BR_BEQ  = 3'd3,
      BR_BNE  = 3'd4
   } br_type_e;

   // IF->ID bus is {pc, inst}; ID->EX adds the two bypassed operands.
   function automatic int fs_to_ds_w(input int xlen);
      return xlen + INST_W;
   endfunction

   function automatic int ds_to_es_w(input int xlen);
      return xlen + INST_W + 2 * xlen;
   endfunction

   localparam int FS_TO_DS_W = fs_to_ds_w(XLEN_DEF);
   localparam int DS_TO_ES_W = ds_to_es_w(XLEN_DEF);

endpackage

// File: rtl/ds_operand_bypass_if.sv
// IF->ID->EX handshake and instruction bus seen by the decode stage.
// slave is the decode stage itself; master is the surrounding pipeline.
interface ds_operand_bypass_if #(
   parameter int XLEN = 32
) ();

   logic            fs_to_ds_valid;
   logic [XLEN-1:0] fs_pc;
   logic [31:0]     fs_inst;
   logic            ds_allowin;
   logic            es_allowin;
   logic            ds_to_es_valid;
   logic [XLEN-1:0] ds_pc;
   logic [31:0]     ds_inst;

   modport master (
      output fs_to_ds_valid, fs_pc, fs_inst, es_allowin,
      input  ds_allowin, ds_to_es_valid, ds_pc, ds_inst
   );

   modport slave (
      input  fs_to_ds_valid, fs_pc, fs_inst, es_allowin,
      output ds_allowin, ds_to_es_valid, ds_pc, ds_inst
   );

endinterface

// File: rtl/ds_operand_bypass_mux.sv
// One operand of the bypass network: priority match over the forwarding sources,
// the resulting value, and a hazard flag when the winning producer is not final yet.
module ds_operand_bypass_mux #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int RA_W    = 5
) (
   input  logic [RA_W-1:0]         addr,
   input  logic                    used,
   input  logic [XLEN-1:0]         rf_data,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [NUM_FWD-1:0]      fwd_we,
   input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]      fwd_ready,
   output logic [XLEN-1:0]         value,
   output logic                    hazard
);

   logic [NUM_FWD-1:0] match;
   logic               sel_ready;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
         assign match[gi] = fwd_valid[gi] & fwd_we[gi] &
                            (fwd_addr[gi*RA_W +: RA_W] == addr) & (addr != '0);
      end
   endgenerate

   // Walk oldest to youngest so the lowest-index match is the last one written.
   always_comb begin
      value     = (addr == '0) ? '0 : rf_data;
      sel_ready = 1'b1;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (match[k]) begin
            value     = fwd_data[k*XLEN +: XLEN];
            sel_ready = fwd_ready[k];
         end
      end
      hazard = used & ~sel_ready;
   end

endmodule

// File: rtl/ds_operand_bypass.sv
// Decode stage: IF->ID latch, regfile read addressing, operand bypass with
// load-use stall, and branch resolution on the bypassed operands.
module ds_operand_bypass
   import ds_operand_bypass_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 3,
   parameter int RA_W    = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   ds_operand_bypass_if.slave      pipe,
   input  logic                    dec_use_rj,
   input  logic                    dec_use_r2,
   input  logic                    dec_r2_is_rd,
   input  logic [2:0]              dec_br_type,
   input  logic [XLEN-1:0]         dec_br_offs,
   output logic [RA_W-1:0]         rf_raddr1,
   output logic [RA_W-1:0]         rf_raddr2,
   input  logic [XLEN-1:0]         rf_rdata1,
   input  logic [XLEN-1:0]         rf_rdata2,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [NUM_FWD-1:0]      fwd_we,
   input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]      fwd_ready,
   output logic [XLEN-1:0]         rj_value,
   output logic [XLEN-1:0]         rkd_value,
   output logic                    br_taken,
   output logic [XLEN-1:0]         br_target
);

   localparam int FS_W = fs_to_ds_w(XLEN);

   logic            ds_valid_reg;
   logic [XLEN-1:0] ds_pc_reg;
   logic [31:0]     ds_inst_reg;
   logic [FS_W-1:0] fs_to_ds_bus;
   logic            ds_ready_go;
   logic            ds_allowin;
   logic            br_cond;
   logic            rj_eq;

   logic [RA_W-1:0] op_addr   [2];
   logic            op_used   [2];
   logic [XLEN-1:0] op_rf     [2];
   logic [XLEN-1:0] op_value  [2];
   logic            op_hazard [2];

   assign fs_to_ds_bus = {pipe.fs_pc, pipe.fs_inst};

   // A wrong-path instruction arriving alongside a taken branch is never marked valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid_reg <= 1'b0;
         ds_pc_reg    <= '0;
         ds_inst_reg  <= '0;
      end else begin
         if (ds_allowin)
            ds_valid_reg <= pipe.fs_to_ds_valid & ~br_taken;
         if (ds_allowin & pipe.fs_to_ds_valid)
            {ds_pc_reg, ds_inst_reg} <= fs_to_ds_bus;
      end
   end

   assign rf_raddr1 = ds_inst_reg[5 +: RA_W];
   assign rf_raddr2 = dec_r2_is_rd ? ds_inst_reg[0 +: RA_W] : ds_inst_reg[10 +: RA_W];

   assign op_addr[0] = rf_raddr1;
   assign op_addr[1] = rf_raddr2;
   assign op_used[0] = dec_use_rj;
   assign op_used[1] = dec_use_r2;
   assign op_rf[0]   = rf_rdata1;
   assign op_rf[1]   = rf_rdata2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_op
         ds_operand_bypass_mux #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD),
            .RA_W    (RA_W)
         ) u_mux (
            .addr      (op_addr[gi]),
            .used      (op_used[gi]),
            .rf_data   (op_rf[gi]),
            .fwd_valid (fwd_valid),
            .fwd_we    (fwd_we),
            .fwd_addr  (fwd_addr),
            .fwd_data  (fwd_data),
            .fwd_ready (fwd_ready),
            .value     (op_value[gi]),
            .hazard    (op_hazard[gi])
         );
      end
   endgenerate

   assign rj_value  = op_value[0];
   assign rkd_value = op_value[1];

   assign ds_ready_go         = ~(op_hazard[0] | op_hazard[1]);
   assign ds_allowin          = ~ds_valid_reg | (ds_ready_go & pipe.es_allowin);
   assign pipe.ds_allowin     = ds_allowin;
   assign pipe.ds_to_es_valid = ds_valid_reg & ds_ready_go;
   assign pipe.ds_pc          = ds_pc_reg;
   assign pipe.ds_inst        = ds_inst_reg;

   assign rj_eq = (rj_value == rkd_value);

   always_comb begin
      br_cond = 1'b0;
      case (br_type_e'(dec_br_type))
         BR_B, BR_JIRL: br_cond = 1'b1;
         BR_BEQ:        br_cond = rj_eq;
         BR_BNE:        br_cond = ~rj_eq;
         default:       br_cond = 1'b0;
      endcase
   end

   // Gated by ds_ready_go so a branch never resolves from a stale operand.
   assign br_taken  = ds_valid_reg & ds_ready_go & br_cond;
   assign br_target = ((br_type_e'(dec_br_type) == BR_JIRL) ? rj_value : ds_pc_reg) + dec_br_offs;

endmodule

// File: tb/tb_ds_operand_bypass.sv
// Self-checking bench for ds_operand_bypass: vector table for single-cycle operand and
// branch cases, hand sequences for stalls/redirects, scoreboard on the ID->EX handoff.
module tb_ds_operand_bypass;
   import ds_operand_bypass_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        dec_use_rj, dec_use_r2, dec_r2_is_rd;
   logic [2:0]  dec_br_type;
   logic [31:0] dec_br_offs;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [2:0]  fwd_valid, fwd_we, fwd_ready;
   logic [14:0] fwd_addr;
   logic [95:0] fwd_data;
   logic [31:0] rj_value, rkd_value, br_target;
   logic        br_taken;

   logic [31:0] rf [32];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } xfer_t;
   xfer_t sb[$];

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd, rj, rk;
      logic        use_rj, use_r2, r2rd;
      logic [2:0]  br;
      logic [31:0] offs;
      logic [2:0]  fv, fw, fr;
      logic [14:0] fa;
      logic [95:0] fd;
      logic [31:0] e_rj, e_rkd;
      logic        e_go, e_br;
      logic [31:0] e_tgt;
   } vec_t;
   vec_t vt [11];

   ds_operand_bypass_if #(.XLEN(32)) pipe ();

   ds_operand_bypass #(.XLEN(32), .NUM_FWD(3), .RA_W(5)) dut (
      .clk          (clk),
      .reset        (reset),
      .pipe         (pipe),
      .dec_use_rj   (dec_use_rj),
      .dec_use_r2   (dec_use_r2),
      .dec_r2_is_rd (dec_r2_is_rd),
      .dec_br_type  (dec_br_type),
      .dec_br_offs  (dec_br_offs),
      .rf_raddr1    (rf_raddr1),
      .rf_raddr2    (rf_raddr2),
      .rf_rdata1    (rf_rdata1),
      .rf_rdata2    (rf_rdata2),
      .fwd_valid    (fwd_valid),
      .fwd_we       (fwd_we),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data),
      .fwd_ready    (fwd_ready),
      .rj_value     (rj_value),
      .rkd_value    (rkd_value),
      .br_taken     (br_taken),
      .br_target    (br_target)
   );

   always #5 clk = ~clk;

   // Regfile model: combinational read, r0 deliberately holds garbage.
   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rj, input logic [4:0] rk);
      return {17'd0, rk, rj, rd};
   endfunction

   task automatic send(input logic [31:0] pc, input logic [31:0] inst, input bit push);
      xfer_t x;
      pipe.fs_to_ds_valid = 1'b1;
      pipe.fs_pc          = pc;
      pipe.fs_inst        = inst;
      if (push) begin
         x.pc   = pc;
         x.inst = inst;
         sb.push_back(x);
      end
   endtask

   task automatic set_dec(input logic urj, input logic ur2, input logic r2rd,
                          input logic [2:0] br, input logic [31:0] offs);
      dec_use_rj   = urj;
      dec_use_r2   = ur2;
      dec_r2_is_rd = r2rd;
      dec_br_type  = br;
      dec_br_offs  = offs;
   endtask

   task automatic set_fwd(input logic [2:0] v, input logic [2:0] w, input logic [2:0] r,
                          input logic [14:0] a, input logic [95:0] d);
      fwd_valid = v;
      fwd_we    = w;
      fwd_ready = r;
      fwd_addr  = a;
      fwd_data  = d;
   endtask

   // Handoff monitor: every instruction EX accepts must be the next one expected.
   always @(negedge clk) begin
      if (!reset && pipe.ds_to_es_valid && pipe.es_allowin) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL handoff_unexpected actual_pc=%h required=none", pipe.ds_pc);
         end else begin
            xfer_t e;
            e = sb.pop_front();
            chk("handoff_pc", pipe.ds_pc, e.pc);
            chk("handoff_inst", pipe.ds_inst, e.inst);
            $display("handoff pc=%h inst=%h", pipe.ds_pc, pipe.ds_inst);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rf[4] = 32'h400;
      rf[5] = 32'd9;
      rf[6] = 32'hA;

      //           pc        rd    rj    rk   urj  ur2  r2rd br       offs          fv      fw      fr      fa                     fd                                         e_rj           e_rkd          go   br   tgt
      vt[0]  = '{32'h1000, 5'd3, 5'd1, 5'd2, 1'b1,1'b1,1'b0,BR_NONE, 32'd0,        3'b000, 3'b000, 3'b000, 15'd0,                 96'd0,                                     32'd5,         32'd7,         1'b1,1'b0,32'd0};
      vt[1]  = '{32'h1010, 5'd3, 5'd1, 5'd2, 1'b1,1'b1,1'b0,BR_NONE, 32'd0,        3'b101, 3'b101, 3'b101, {5'd1,5'd0,5'd1},      {32'h22,32'h0,32'h11},                     32'h11,        32'd7,         1'b1,1'b0,32'd0};
      vt[2]  = '{32'h1020, 5'd3, 5'd1, 5'd2, 1'b1,1'b1,1'b0,BR_NONE, 32'd0,        3'b110, 3'b100, 3'b110, {5'd2,5'd1,5'd0},      {32'h33,32'hEE,32'h0},                     32'd5,         32'h33,        1'b1,1'b0,32'd0};
      vt[3]  = '{32'h1030, 5'd1, 5'd1, 5'd0, 1'b1,1'b0,1'b0,BR_JIRL, 32'd8,        3'b010, 3'b010, 3'b010, {5'd0,5'd1,5'd0},      {32'h0,32'h1C00_0000,32'h0},               32'h1C00_0000, 32'd0,         1'b1,1'b1,32'h1C00_0008};
      vt[4]  = '{32'h1040, 5'd3, 5'd0, 5'd2, 1'b1,1'b1,1'b0,BR_NONE, 32'd0,        3'b101, 3'b101, 3'b100, {5'd2,5'd0,5'd0},      {32'h77,32'h0,32'h99},                     32'd0,         32'h77,        1'b1,1'b0,32'd0};
      vt[5]  = '{32'h1050, 5'd6, 5'd5, 5'd0, 1'b1,1'b1,1'b1,BR_BEQ,  32'h20,       3'b000, 3'b000, 3'b000, 15'd0,                 96'd0,                                     32'd9,         32'hA,         1'b1,1'b0,32'd0};
      vt[6]  = '{32'h1060, 5'd6, 5'd5, 5'd0, 1'b1,1'b1,1'b1,BR_BNE,  32'hFFFF_FFF0, 3'b000, 3'b000, 3'b000, 15'd0,                 96'd0,                                     32'd9,         32'hA,         1'b1,1'b1,32'h1050};
      vt[7]  = '{32'h1070, 5'd3, 5'd1, 5'd2, 1'b0,1'b0,1'b0,BR_B,    32'h100,      3'b000, 3'b000, 3'b000, 15'd0,                 96'd0,                                     32'd5,         32'd7,         1'b1,1'b1,32'h1170};
      vt[8]  = '{32'h1080, 5'd3, 5'd1, 5'd7, 1'b1,1'b0,1'b0,BR_NONE, 32'd0,        3'b001, 3'b001, 3'b000, {5'd0,5'd0,5'd7},      {32'h0,32'h0,32'h70},                      32'd5,         32'h70,        1'b1,1'b0,32'd0};
      vt[9]  = '{32'h1090, 5'd3, 5'd1, 5'd2, 1'b1,1'b0,1'b0,BR_NONE, 32'd0,        3'b101, 3'b101, 3'b100, {5'd1,5'd0,5'd1},      {32'hBB,32'h0,32'hAA},                     32'hAA,        32'd7,         1'b0,1'b0,32'd0};
      vt[10] = '{32'h10A0, 5'd2, 5'd1, 5'd0, 1'b1,1'b1,1'b1,BR_BEQ,  32'd8,        3'b111, 3'b110, 3'b111, {5'd2,5'd1,5'd2},      {32'h123,32'h123,32'h0},                   32'h123,       32'h123,       1'b1,1'b1,32'h10A8};

      reset = 1'b1;
      pipe.fs_to_ds_valid = 1'b0;
      pipe.fs_pc          = '0;
      pipe.fs_inst        = '0;
      pipe.es_allowin     = 1'b1;
      set_dec(1'b0, 1'b0, 1'b0, BR_NONE, 32'd0);
      set_fwd(3'b000, 3'b000, 3'b000, 15'd0, 96'd0);

      // Reset state
      @(posedge clk);
      @(negedge clk);
      chk("rst_to_es_valid", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
      chk("rst_allowin", {31'd0, pipe.ds_allowin}, 32'd1);
      chk("rst_ds_pc", pipe.ds_pc, 32'd0);
      chk("rst_ds_inst", pipe.ds_inst, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Table-driven single-instruction cases
      for (int i = 0; i < 11; i++) begin
         send(vt[i].pc, mk(vt[i].rd, vt[i].rj, vt[i].rk), 1'b1);
         @(posedge clk);
         #1;
         pipe.fs_to_ds_valid = 1'b0;
         set_dec(vt[i].use_rj, vt[i].use_r2, vt[i].r2rd, vt[i].br, vt[i].offs);
         set_fwd(vt[i].fv, vt[i].fw, vt[i].fr, vt[i].fa, vt[i].fd);
         @(negedge clk);
         chk($sformatf("v%0d_rj", i), rj_value, vt[i].e_rj);
         chk($sformatf("v%0d_rkd", i), rkd_value, vt[i].e_rkd);
         chk($sformatf("v%0d_to_es", i), {31'd0, pipe.ds_to_es_valid}, {31'd0, vt[i].e_go});
         chk($sformatf("v%0d_allowin", i), {31'd0, pipe.ds_allowin}, {31'd0, vt[i].e_go});
         chk($sformatf("v%0d_br", i), {31'd0, br_taken}, {31'd0, vt[i].e_br});
         if (vt[i].e_br)
            chk($sformatf("v%0d_tgt", i), br_target, vt[i].e_tgt);
         $display("vec %0d pc=%h rj=%h rkd=%h go=%b br=%b tgt=%h",
                  i, pipe.ds_pc, rj_value, rkd_value, pipe.ds_to_es_valid, br_taken, br_target);
         @(posedge clk);
         #1;
         set_fwd(3'b000, 3'b000, 3'b000, 15'd0, 96'd0);
         set_dec(1'b0, 1'b0, 1'b0, BR_NONE, 32'd0);
      end

      // Load-use: one stall cycle, then MEM data bypassed; next inst waits
      send(32'h2000, mk(5'd5, 5'd4, 5'd0), 1'b1);
      @(posedge clk);
      #1;
      send(32'h2004, mk(5'd6, 5'd1, 5'd2), 1'b1);
      set_dec(1'b1, 1'b0, 1'b0, BR_NONE, 32'd0);
      set_fwd(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd4}, 96'd0);
      @(negedge clk);
      chk("lu_stall_allowin", {31'd0, pipe.ds_allowin}, 32'd0);
      chk("lu_stall_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      $display("loaduse stall pc=%h allowin=%b", pipe.ds_pc, pipe.ds_allowin);
      @(posedge clk);
      #1;
      set_fwd(3'b010, 3'b010, 3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0});
      @(negedge clk);
      chk("lu_go_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd1);
      chk("lu_go_rj", rj_value, 32'h44);
      chk("lu_go_pc_held", pipe.ds_pc, 32'h2000);
      chk("lu_go_allowin", {31'd0, pipe.ds_allowin}, 32'd1);
      @(posedge clk);
      #1;
      pipe.fs_to_ds_valid = 1'b0;
      set_fwd(3'b000, 3'b000, 3'b000, 15'd0, 96'd0);
      set_dec(1'b1, 1'b1, 1'b0, BR_NONE, 32'd0);
      @(negedge clk);
      chk("lu_next_pc", pipe.ds_pc, 32'h2004);
      chk("lu_next_rj", rj_value, 32'd5);
      chk("lu_next_rkd", rkd_value, 32'd7);
      @(posedge clk);
      #1;

      // beq on a pending load: no resolve while stalled, then taken, wrong path dropped
      send(32'h3000, mk(5'd5, 5'd5, 5'd0), 1'b1);
      @(posedge clk);
      #1;
      send(32'h3004, mk(5'd7, 5'd1, 5'd2), 1'b0);
      set_dec(1'b1, 1'b1, 1'b1, BR_BEQ, 32'h40);
      set_fwd(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd5}, 96'd0);
      @(negedge clk);
      chk("beq_stall_br", {31'd0, br_taken}, 32'd0);
      chk("beq_stall_allowin", {31'd0, pipe.ds_allowin}, 32'd0);
      @(posedge clk);
      #1;
      set_fwd(3'b001, 3'b001, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h55});
      @(negedge clk);
      chk("beq_go_br", {31'd0, br_taken}, 32'd1);
      chk("beq_go_tgt", br_target, 32'h3040);
      chk("beq_go_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd1);
      $display("beq resolve pc=%h br=%b tgt=%h", pipe.ds_pc, br_taken, br_target);
      @(posedge clk);
      #1;
      pipe.fs_to_ds_valid = 1'b0;
      set_fwd(3'b000, 3'b000, 3'b000, 15'd0, 96'd0);
      set_dec(1'b0, 1'b0, 1'b0, BR_NONE, 32'd0);
      @(negedge clk);
      chk("beq_drop_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      chk("beq_drop_br", {31'd0, br_taken}, 32'd0);
      @(posedge clk);
      #1;

      // EX back-pressure for 3 cycles: latch held, nothing new accepted
      send(32'h4000, mk(5'd3, 5'd1, 5'd2), 1'b1);
      set_dec(1'b1, 1'b1, 1'b0, BR_NONE, 32'd0);
      @(posedge clk);
      #1;
      send(32'h4004, mk(5'd3, 5'd2, 5'd1), 1'b1);
      pipe.es_allowin = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd1);
         chk("bp_pc_held", pipe.ds_pc, 32'h4000);
         chk("bp_allowin", {31'd0, pipe.ds_allowin}, 32'd0);
         $display("backpressure cycle %0d pc=%h", c, pipe.ds_pc);
         @(posedge clk);
         #1;
      end
      pipe.es_allowin = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      pipe.fs_to_ds_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_pc", pipe.ds_pc, 32'h4004);
      chk("bp_next_rj", rj_value, 32'd7);
      chk("bp_next_rkd", rkd_value, 32'd5);
      @(posedge clk);
      #1;

      // Taken branch held by EX back-pressure keeps redirecting
      send(32'h5000, mk(5'd0, 5'd1, 5'd2), 1'b1);
      @(posedge clk);
      #1;
      send(32'h5004, mk(5'd3, 5'd1, 5'd2), 1'b0);
      set_dec(1'b0, 1'b0, 1'b0, BR_B, 32'h200);
      pipe.es_allowin = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("bhold_br", {31'd0, br_taken}, 32'd1);
         chk("bhold_tgt", br_target, 32'h5200);
         chk("bhold_allowin", {31'd0, pipe.ds_allowin}, 32'd0);
         @(posedge clk);
         #1;
      end
      pipe.es_allowin = 1'b1;
      @(negedge clk);
      chk("bhold_release_br", {31'd0, br_taken}, 32'd1);
      @(posedge clk);
      #1;
      pipe.fs_to_ds_valid = 1'b0;
      set_dec(1'b0, 1'b0, 1'b0, BR_NONE, 32'd0);
      @(negedge clk);
      chk("bhold_drop_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a stalled branch
      send(32'h6000, mk(5'd3, 5'd1, 5'd2), 1'b1);
      @(posedge clk);
      #1;
      pipe.fs_to_ds_valid = 1'b0;
      set_dec(1'b1, 1'b0, 1'b0, BR_B, 32'h10);
      set_fwd(3'b001, 3'b001, 3'b000, {5'd0, 5'd0, 5'd1}, 96'd0);
      @(negedge clk);
      chk("rs_stall_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      chk("rs_stall_br", {31'd0, br_taken}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_fwd(3'b000, 3'b000, 3'b000, 15'd0, 96'd0);
      @(negedge clk);
      chk("rs_after_to_es", {31'd0, pipe.ds_to_es_valid}, 32'd0);
      chk("rs_after_br", {31'd0, br_taken}, 32'd0);
      chk("rs_after_allowin", {31'd0, pipe.ds_allowin}, 32'd1);
      chk("rs_after_pc", pipe.ds_pc, 32'd0);
      set_dec(1'b0, 1'b0, 1'b0, BR_NONE, 32'd0);
      @(posedge clk);
      #1;

      chk("sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
